// File: rtl/req_enc_pkg.sv
// Shared types and constants for the 4-to-2 request encoder.
package req_enc_pkg;

   localparam int NUM_REQ = 4;
   localparam int CODE_W  = 2;

   typedef enum logic {IDLE, PRESENT} state_t;
   typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/req_sync_edge.sv
// One request line: SYNC_STAGES-deep synchroniser followed by a falling-edge detector.
module req_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_n,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic                   s;
   logic                   prev_d, prev_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], req_n};
      s      = sync_q[SYNC_STAGES-1];
      prev_d = s;
      fall   = prev_q & ~s;
   end

   // Flops reset high so a line held low through reset still yields one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/req_encoder_4to2.sv
// Captures falling edges on four active-low request lines and presents the winning index
// on a registered valid/ready port. Define REQ_ENC_ROUND_ROBIN_EN for rotating priority.
module req_encoder_4to2
   import req_enc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cs_n,
   input  logic [NUM_REQ-1:0] req_n,
   output logic [CODE_W-1:0]  code,
   output logic               valid,
   input  logic               ready,
   output logic [NUM_REQ-1:0] pending,
   output logic               overrun
);

   logic [NUM_REQ-1:0] fall, set, clr;
   logic [NUM_REQ-1:0] pending_d, pending_q;
   logic               accept;
   state_t             state_d, state_q;
   code_t              code_d, code_q;
   logic               valid_d, valid_q;
   logic               overrun_d, overrun_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
      req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .req_n (req_n[i]),
         .fall  (fall[i])
      );
   end

`ifdef REQ_ENC_ROUND_ROBIN_EN
   code_t ptr_d, ptr_q;

   // Search starts just after the last accepted index; later assignments win.
   function automatic code_t pick_winner(input logic [NUM_REQ-1:0] p, input code_t ptr);
      code_t w;
      code_t idx;
      w = ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ptr + code_t'(k);
         if (p[idx]) w = idx;
      end
      return w;
   endfunction
`else
   // Fixed priority: highest index wins.
   function automatic code_t pick_winner(input logic [NUM_REQ-1:0] p);
      code_t w;
      w = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (p[i]) w = code_t'(i);
      return w;
   endfunction
`endif

   always_comb begin
      accept    = valid_q & ready;
      set       = fall & {NUM_REQ{~cs_n}};
      clr       = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << code_q) : '0;
      // A set landing on the line being cleared wins and is not an overrun.
      pending_d = (pending_q & ~clr) | set;
      overrun_d = |(set & pending_q & ~clr);

      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
`ifdef REQ_ENC_ROUND_ROBIN_EN
               code_d = pick_winner(pending_q, ptr_q);
`else
               code_d = pick_winner(pending_q);
`endif
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (accept) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef REQ_ENC_ROUND_ROBIN_EN
      ptr_d = accept ? code_q : ptr_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         code_q    <= '0;
         valid_q   <= 1'b0;
         pending_q <= '0;
         overrun_q <= 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
`ifdef REQ_ENC_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule
